// File: rtl/gf22_sram_be_wbuf_banked_pkg.sv
// Shared helpers for the banked byte-masked SRAM: bank count, bank select,
// bit-mask merge and the per-bank operation encoding.
package gf22_sram_pkg;

    // Widest word the merge helper supports; DATA_W must not exceed it.
    localparam int MERGE_W = 256;

    typedef enum logic [1:0] {
        BANK_IDLE   = 2'd0,
        BANK_READ   = 2'd1,
        BANK_DRAIN  = 2'd2,
        BANK_DIRECT = 2'd3
    } bank_op_e;

    function automatic int nbanks(input int addr_w, input int bank_addr_w);
        return 1 << (addr_w - bank_addr_w);
    endfunction

    function automatic int unsigned bank_sel(input logic [31:0] addr, input int bank_addr_w);
        return addr >> bank_addr_w;
    endfunction

    function automatic logic [MERGE_W-1:0] byte_merge(input logic [MERGE_W-1:0] base,
                                                      input logic [MERGE_W-1:0] upd,
                                                      input logic [MERGE_W-1:0] mask);
        return (base & ~mask) | (upd & mask);
    endfunction

endpackage

// File: rtl/gf22_sram_be_wbuf_banked_if.sv
// Write/read port bundle of the banked SRAM; master drives requests, slave is the memory.
interface gf22_sram_be_wbuf_banked_if #(
    parameter int ADDR_W = 14,
    parameter int DATA_W = 32
);
    logic              CE0;
    logic [ADDR_W-1:0] A0;
    logic [DATA_W-1:0] D0;
    logic [DATA_W-1:0] WEM0;
    logic              RDY0;
    logic              CE1;
    logic [ADDR_W-1:0] A1;
    logic [DATA_W-1:0] Q1;
    logic              QV1;
    logic [31:0]       STAT_CONFLICTS;
    logic [31:0]       STAT_STALLS;

    modport master (output CE0, A0, D0, WEM0, CE1, A1,
                    input  RDY0, Q1, QV1, STAT_CONFLICTS, STAT_STALLS);
    modport slave  (input  CE0, A0, D0, WEM0, CE1, A1,
                    output RDY0, Q1, QV1, STAT_CONFLICTS, STAT_STALLS);
endinterface

// File: rtl/gf22_sram_be_wbuf_banked_wbuf.sv
// In-order write buffer: wrap-around FIFO plus a forward merge of every
// valid entry matching the look-up address, oldest to youngest.
module gf22_sram_wbuf
    import gf22_sram_pkg::*;
#(
    parameter  int ADDR_W = 14,
    parameter  int DATA_W = 32,
    parameter  int DEPTH  = 2,
    localparam int PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CNT_W  = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_push,
    input  logic [ADDR_W-1:0] i_push_addr,
    input  logic [DATA_W-1:0] i_push_data,
    input  logic [DATA_W-1:0] i_push_mask,
    input  logic              i_pop,
    input  logic [ADDR_W-1:0] i_look_addr,
    output logic [ADDR_W-1:0] o_head_addr,
    output logic [DATA_W-1:0] o_head_data,
    output logic [DATA_W-1:0] o_head_mask,
    output logic [CNT_W-1:0]  o_count,
    output logic [DATA_W-1:0] o_fwd_data,
    output logic [DATA_W-1:0] o_fwd_mask
);

    logic [ADDR_W-1:0] r_addr [DEPTH];
    logic [DATA_W-1:0] r_data [DEPTH];
    logic [DATA_W-1:0] r_mask [DEPTH];
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [CNT_W-1:0]  r_count;
    logic [PTR_W-1:0]  w_k;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        if (p == PTR_W'(DEPTH - 1)) return '0;
        else                        return p + PTR_W'(1);
    endfunction

    // Entry storage, pointers and occupancy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_addr[i] <= '0;
                r_data[i] <= '0;
                r_mask[i] <= '0;
            end
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_push) begin
                r_addr[r_wr_ptr] <= i_push_addr;
                r_data[r_wr_ptr] <= i_push_data;
                r_mask[r_wr_ptr] <= i_push_mask;
                r_wr_ptr         <= ptr_inc(r_wr_ptr);
            end
            if (i_pop) begin
                r_rd_ptr <= ptr_inc(r_rd_ptr);
            end
            case ({i_push, i_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Walk entries from head to tail so younger bytes overwrite older ones.
    always_comb begin
        o_fwd_data = '0;
        o_fwd_mask = '0;
        w_k        = r_rd_ptr;
        for (int i = 0; i < DEPTH; i++) begin
            w_k = PTR_W'((int'(r_rd_ptr) + i) % DEPTH);
            if ((i < int'(r_count)) && (r_addr[w_k] == i_look_addr)) begin
                o_fwd_data = DATA_W'(byte_merge(MERGE_W'(o_fwd_data), MERGE_W'(r_data[w_k]),
                                                MERGE_W'(r_mask[w_k])));
                o_fwd_mask = o_fwd_mask | r_mask[w_k];
            end else begin
                o_fwd_mask = o_fwd_mask;
            end
        end
    end

    assign o_head_addr = r_addr[r_rd_ptr];
    assign o_head_data = r_data[r_rd_ptr];
    assign o_head_mask = r_mask[r_rd_ptr];
    assign o_count     = r_count;

endmodule

// File: rtl/gf22_sram_be_wbuf_banked.sv
// 1-write/1-read byte-masked SRAM over single-port banks with a conflict write buffer.
// Optional statistics counters enabled by defining GF22_SRAM_BE_STATS_EN.
module gf22_sram_be_wbuf_banked
    import gf22_sram_pkg::*;
#(
    parameter int DATA_W      = 32,
    parameter int ADDR_W      = 14,
    parameter int BANK_ADDR_W = 13,
    parameter int WBUF_DEPTH  = 2
) (
    input  logic                         CLK,
    input  logic                         RSTN,
    gf22_sram_be_wbuf_banked_if.slave    io_bus
);

    localparam int SEL_W      = ADDR_W - BANK_ADDR_W;
    localparam int NBANKS     = nbanks(ADDR_W, BANK_ADDR_W);
    localparam int CNT_W      = $clog2(WBUF_DEPTH + 1);
    localparam int BANK_WORDS = 1 << BANK_ADDR_W;

    logic [SEL_W-1:0]       w_rb, w_wb, w_hb;
    logic [ADDR_W-1:0]      w_head_addr;
    logic [DATA_W-1:0]      w_head_data, w_head_mask;
    logic [CNT_W-1:0]       w_count;
    logic [DATA_W-1:0]      w_fwd_data, w_fwd_mask;
    logic                   w_rd, w_rdy, w_acc, w_empty, w_drain, w_direct, w_push;
    logic [BANK_ADDR_W-1:0] w_waddr;
    logic [DATA_W-1:0]      w_wdata, w_wmask;
    logic [DATA_W-1:0]      w_bank_q [NBANKS];
    logic                   r_qv;
    logic [SEL_W-1:0]       r_rsel;
    logic [DATA_W-1:0]      r_fwd, r_fmask;

    assign w_rb     = SEL_W'(bank_sel(32'(io_bus.A1), BANK_ADDR_W));
    assign w_wb     = SEL_W'(bank_sel(32'(io_bus.A0), BANK_ADDR_W));
    assign w_hb     = SEL_W'(bank_sel(32'(w_head_addr), BANK_ADDR_W));
    assign w_rd     = io_bus.CE1;
    assign w_rdy    = (w_count < CNT_W'(WBUF_DEPTH));
    assign w_acc    = io_bus.CE0 & w_rdy & (|io_bus.WEM0);
    assign w_empty  = (w_count == '0);
    // The read owns its bank; buffered writes drain only to other banks.
    assign w_drain  = !w_empty & (!w_rd | (w_hb != w_rb));
    assign w_direct = w_acc & w_empty & (!w_rd | (w_wb != w_rb));
    assign w_push   = w_acc & !w_direct;

    gf22_sram_wbuf #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .DEPTH  (WBUF_DEPTH)
    ) u_wbuf (
        .clk         (CLK),
        .rst_n       (RSTN),
        .i_push      (w_push),
        .i_push_addr (io_bus.A0),
        .i_push_data (io_bus.D0),
        .i_push_mask (io_bus.WEM0),
        .i_pop       (w_drain),
        .i_look_addr (io_bus.A1),
        .o_head_addr (w_head_addr),
        .o_head_data (w_head_data),
        .o_head_mask (w_head_mask),
        .o_count     (w_count),
        .o_fwd_data  (w_fwd_data),
        .o_fwd_mask  (w_fwd_mask)
    );

    // Drain and direct write never coincide, so one shared write port suffices.
    always_comb begin
        w_waddr = w_head_addr[BANK_ADDR_W-1:0];
        w_wdata = w_head_data;
        w_wmask = w_head_mask;
        if (w_drain) begin
            w_waddr = w_head_addr[BANK_ADDR_W-1:0];
        end else begin
            w_waddr = io_bus.A0[BANK_ADDR_W-1:0];
            w_wdata = io_bus.D0;
            w_wmask = io_bus.WEM0;
        end
    end

    for (genvar g = 0; g < NBANKS; g++) begin : g_bank
        logic [DATA_W-1:0] r_mem [BANK_WORDS];
        logic [DATA_W-1:0] r_q;
        bank_op_e          w_op;
        logic              w_we;

        // One access per bank per cycle, in read/drain/direct priority.
        always_comb begin
            w_op = BANK_IDLE;
            if (w_rd && (w_rb == SEL_W'(g)))            w_op = BANK_READ;
            else if (w_drain && (w_hb == SEL_W'(g)))    w_op = BANK_DRAIN;
            else if (w_direct && (w_wb == SEL_W'(g)))   w_op = BANK_DIRECT;
            else                                        w_op = BANK_IDLE;
            case (w_op)
                BANK_DRAIN, BANK_DIRECT: w_we = RSTN;
                default:                 w_we = 1'b0;
            endcase
        end

        // Single-port macro array; contents survive reset.
        always_ff @(posedge CLK) begin
            if (w_we) begin
                r_mem[w_waddr] <= DATA_W'(byte_merge(MERGE_W'(r_mem[w_waddr]),
                                                     MERGE_W'(w_wdata), MERGE_W'(w_wmask)));
            end
        end

        // Macro output latch.
        always_ff @(posedge CLK or negedge RSTN) begin
            if (!RSTN)                  r_q <= '0;
            else if (w_op == BANK_READ) r_q <= r_mem[io_bus.A1[BANK_ADDR_W-1:0]];
        end

        assign w_bank_q[g] = r_q;
    end

    // Read-side pipeline: bank choice and forward overlay captured with the read.
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            r_qv    <= 1'b0;
            r_rsel  <= '0;
            r_fwd   <= '0;
            r_fmask <= '0;
        end else begin
            r_qv <= w_rd;
            if (w_rd) begin
                r_rsel  <= w_rb;
                r_fwd   <= w_fwd_data;
                r_fmask <= w_fwd_mask;
            end
        end
    end

    assign io_bus.RDY0 = w_rdy;
    assign io_bus.QV1  = r_qv;
    assign io_bus.Q1   = DATA_W'(byte_merge(MERGE_W'(w_bank_q[r_rsel]), MERGE_W'(r_fwd),
                                            MERGE_W'(r_fmask)));

`ifdef GF22_SRAM_BE_STATS_EN
    logic [31:0] r_conflicts, r_stalls;

    // Saturating conflict and stall counters.
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            r_conflicts <= 32'd0;
            r_stalls    <= 32'd0;
        end else begin
            if (io_bus.CE0 && w_rdy && w_rd && (w_wb == w_rb) && (r_conflicts != 32'hFFFF_FFFF))
                r_conflicts <= r_conflicts + 32'd1;
            if (io_bus.CE0 && !w_rdy && (r_stalls != 32'hFFFF_FFFF))
                r_stalls <= r_stalls + 32'd1;
        end
    end

    assign io_bus.STAT_CONFLICTS = r_conflicts;
    assign io_bus.STAT_STALLS    = r_stalls;
`else
    assign io_bus.STAT_CONFLICTS = 32'd0;
    assign io_bus.STAT_STALLS    = 32'd0;
`endif

endmodule

// File: tb/tb_gf22_sram_be_wbuf_banked.sv
// Randomised bench: a queue-of-pending-writes memory model predicts RDY0, Q1/QV1 and stats.
module tb_gf22_sram_be_wbuf_banked;

    localparam int AW = 14, DW = 32, BAW = 13, DEPTH = 2;
`ifdef GF22_SRAM_BE_STATS_EN
    localparam bit STATS_ON = 1'b1;
`else
    localparam bit STATS_ON = 1'b0;
`endif

    logic clk, rstn;
    int   checks = 0, errors = 0;

    gf22_sram_be_wbuf_banked_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    gf22_sram_be_wbuf_banked #(.DATA_W(DW), .ADDR_W(AW), .BANK_ADDR_W(BAW), .WBUF_DEPTH(DEPTH))
        dut (.CLK(clk), .RSTN(rstn), .io_bus(bus.slave));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct { logic [AW-1:0] addr; logic [DW-1:0] data; logic [DW-1:0] mask; } wr_t;

    logic [DW-1:0] mdl_bank [int];
    wr_t           mdl_q [$];
    logic          exp_qv, exp_rdy, last_acc;
    logic [DW-1:0] exp_q;
    logic [31:0]   exp_conf, exp_stall;
    logic [AW-1:0] pool [8];

    function automatic int bank_of(input logic [AW-1:0] a);
        return int'(a) / (1 << BAW);
    endfunction

    function automatic logic [DW-1:0] committed(input logic [AW-1:0] a);
        return mdl_bank.exists(int'(a)) ? mdl_bank[int'(a)] : '0;
    endfunction

    // What a read of address a sees: bank word overlaid by pending writes, oldest first.
    function automatic logic [DW-1:0] visible(input logic [AW-1:0] a);
        logic [DW-1:0] v;
        v = committed(a);
        foreach (mdl_q[i])
            if (mdl_q[i].addr == a) v = (v & ~mdl_q[i].mask) | (mdl_q[i].data & mdl_q[i].mask);
        return v;
    endfunction

    task automatic commit(input wr_t w);
        mdl_bank[int'(w.addr)] = (committed(w.addr) & ~w.mask) | (w.data & w.mask);
    endtask

    task automatic mdl_reset();
        mdl_q.delete();
        exp_qv = 1'b0; exp_q = '0; exp_rdy = 1'b1;
        exp_conf = 32'd0; exp_stall = 32'd0;
    endtask

    // One clock of stimulus; model applies the spec's read/drain/write priorities.
    task automatic drive(input logic ce0, input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                         input logic [DW-1:0] wem0, input logic ce1, input logic [AW-1:0] a1);
        logic rdy, was_empty;
        logic [DW-1:0] rval;
        wr_t w;
        @(negedge clk);
        bus.CE0 = ce0; bus.A0 = a0; bus.D0 = d0; bus.WEM0 = wem0; bus.CE1 = ce1; bus.A1 = a1;
        rdy       = (mdl_q.size() < DEPTH);
        was_empty = (mdl_q.size() == 0);
        rval      = visible(a1);
        if (ce0 && !rdy) exp_stall++;
        if (ce0 && rdy && ce1 && bank_of(a0) == bank_of(a1)) exp_conf++;
        if (!was_empty && (!ce1 || bank_of(mdl_q[0].addr) != bank_of(a1))) begin
            commit(mdl_q[0]);
            void'(mdl_q.pop_front());
        end
        last_acc = ce0 && rdy;
        if (ce0 && rdy && wem0 != '0) begin
            w = '{a0, d0, wem0};
            if (was_empty && (!ce1 || bank_of(a0) != bank_of(a1))) commit(w);
            else mdl_q.push_back(w);
        end
        @(posedge clk);
        #1;
        exp_qv = ce1;
        if (ce1) exp_q = rval;
        exp_rdy = (mdl_q.size() < DEPTH);
    endtask

    task automatic idle();
        drive(1'b0, '0, '0, '0, 1'b0, '0);
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        bus.CE0 = 1'b0; bus.A0 = '0; bus.D0 = '0; bus.WEM0 = '0; bus.CE1 = 1'b0; bus.A1 = '0;
        mdl_reset();
        repeat (3) @(posedge clk);
        #2;
        checks++; if (bus.RDY0 !== 1'b1) begin errors++; $display("FAIL reset_rdy: got %b exp 1", bus.RDY0); end
        checks++; if (bus.QV1 !== 1'b0) begin errors++; $display("FAIL reset_qv: got %b exp 0", bus.QV1); end
        checks++; if (bus.Q1 !== 32'h0) begin errors++; $display("FAIL reset_q: got %h exp 0", bus.Q1); end
        checks++; if (bus.STAT_CONFLICTS !== 32'd0 || bus.STAT_STALLS !== 32'd0) begin
            errors++; $display("FAIL reset_stats: got %0d/%0d exp 0/0", bus.STAT_CONFLICTS, bus.STAT_STALLS); end
        @(negedge clk);
        rstn = 1'b1;
        foreach (pool[i]) drive(1'b1, pool[i], $urandom, '1, 1'b0, '0);
    endtask

    task automatic test_basic();
        drive(1'b1, 14'h0005, 32'hAABBCCDD, '1, 1'b0, '0);
        checks++; if (bus.RDY0 !== 1'b1) begin errors++; $display("FAIL basic_rdy: got %b exp 1", bus.RDY0); end
        drive(1'b0, '0, '0, '0, 1'b1, 14'h0005);
        checks++; if (bus.QV1 !== 1'b1) begin errors++; $display("FAIL basic_qv: got %b exp 1", bus.QV1); end
        checks++; if (bus.Q1 !== 32'hAABBCCDD) begin errors++; $display("FAIL basic_q: got %h exp aabbccdd", bus.Q1); end
        idle();
        checks++; if (bus.QV1 !== 1'b0 || bus.Q1 !== exp_q) begin
            errors++; $display("FAIL basic_hold: got qv=%b q=%h exp qv=0 q=%h", bus.QV1, bus.Q1, exp_q); end
    endtask

    task automatic test_conflict_forward();
        logic [DW-1:0] d;
        d = $urandom;
        drive(1'b1, 14'h2001, d, '1, 1'b1, 14'h2003);
        checks++; if (bus.RDY0 !== 1'b1) begin errors++; $display("FAIL cf_rdy: got %b exp 1", bus.RDY0); end
        checks++; if (int'(dut.u_wbuf.r_count) != 1) begin
            errors++; $display("FAIL cf_count: got %0d exp 1", dut.u_wbuf.r_count); end
        checks++; if (bus.Q1 !== exp_q) begin errors++; $display("FAIL cf_old: got %h exp %h", bus.Q1, exp_q); end
        drive(1'b0, '0, '0, '0, 1'b1, 14'h2001);
        checks++; if (bus.Q1 !== d || bus.QV1 !== 1'b1) begin
            errors++; $display("FAIL cf_fwd: got %h/%b exp %h/1", bus.Q1, bus.QV1, d); end
        idle();
        checks++; if (int'(dut.u_wbuf.r_count) != 0) begin
            errors++; $display("FAIL cf_drain: got %0d exp 0", dut.u_wbuf.r_count); end
        drive(1'b0, '0, '0, '0, 1'b1, 14'h2001);
        checks++; if (bus.Q1 !== d) begin errors++; $display("FAIL cf_bank: got %h exp %h", bus.Q1, d); end
    endtask

    task automatic test_read_before_write();
        logic [DW-1:0] old;
        old = visible(14'h0010);
        drive(1'b1, 14'h0010, 32'h11111111, '1, 1'b1, 14'h0010);
        checks++; if (bus.Q1 !== old) begin errors++; $display("FAIL rbw_old: got %h exp %h", bus.Q1, old); end
        drive(1'b0, '0, '0, '0, 1'b1, 14'h0010);
        checks++; if (bus.Q1 !== 32'h11111111) begin errors++; $display("FAIL rbw_new: got %h exp 11111111", bus.Q1); end
        idle();
    endtask

    task automatic test_fill();
        logic [AW-1:0] wa [3];
        logic [DW-1:0] wd [3], wm [3];
        int accepted, cyc;
        wa = '{14'h0021, 14'h0021, 14'h0100};
        wd = '{$urandom, $urandom, $urandom};
        wm = '{32'hFFFFFFFF, 32'h00FF00FF, 32'hFFFFFFFF};
        accepted = 0; cyc = 0;
        while (accepted < 3 && cyc < 12) begin
            drive(1'b1, wa[accepted], wd[accepted], wm[accepted], cyc < 4, 14'h0020);
            if (last_acc) begin
                accepted++;
                if (accepted == 2) begin
                    checks++; if (bus.RDY0 !== 1'b0) begin errors++; $display("FAIL fill_full: got %b exp 0", bus.RDY0); end
                end
            end
            checks++; if (bus.RDY0 !== exp_rdy || bus.Q1 !== exp_q) begin
                errors++; $display("FAIL fill_cycle%0d: got rdy=%b q=%h exp rdy=%b q=%h", cyc, bus.RDY0, bus.Q1, exp_rdy, exp_q); end
            cyc++;
        end
        checks++; if (accepted != 3 || cyc != 6) begin
            errors++; $display("FAIL fill_accepts: got %0d in %0d cycles exp 3 in 6", accepted, cyc); end
        idle(); idle();
        drive(1'b0, '0, '0, '0, 1'b1, 14'h0021);
        checks++; if (bus.Q1 !== ((wd[0] & ~wm[1]) | (wd[1] & wm[1]))) begin
            errors++; $display("FAIL fill_order: got %h exp %h", bus.Q1, (wd[0] & ~wm[1]) | (wd[1] & wm[1])); end
        drive(1'b0, '0, '0, '0, 1'b1, 14'h0100);
        checks++; if (bus.Q1 !== wd[2]) begin errors++; $display("FAIL fill_third: got %h exp %h", bus.Q1, wd[2]); end
        checks++; if (bus.STAT_CONFLICTS !== (STATS_ON ? exp_conf : 32'd0) ||
                      bus.STAT_STALLS !== (STATS_ON ? exp_stall : 32'd0)) begin
            errors++; $display("FAIL fill_stats: got %0d/%0d exp %0d/%0d", bus.STAT_CONFLICTS, bus.STAT_STALLS,
                               STATS_ON ? exp_conf : 32'd0, STATS_ON ? exp_stall : 32'd0); end
    endtask

    task automatic test_partial_mask();
        drive(1'b1, 14'h0100, 32'h12345678, '1, 1'b0, '0);
        drive(1'b1, 14'h0100, 32'h0000BEEF, 32'h0000FFFF, 1'b1, 14'h0005);
        drive(1'b0, '0, '0, '0, 1'b1, 14'h0100);
        checks++; if (bus.Q1 !== 32'h1234BEEF) begin errors++; $display("FAIL pm_fwd: got %h exp 1234beef", bus.Q1); end
        idle();
        drive(1'b0, '0, '0, '0, 1'b1, 14'h0100);
        checks++; if (bus.Q1 !== 32'h1234BEEF) begin errors++; $display("FAIL pm_bank: got %h exp 1234beef", bus.Q1); end
    endtask

    task automatic test_random();
        logic [DW-1:0] m;
        for (int n = 0; n < 400; n++) begin
            m = '0;
            for (int b = 0; b < DW / 8; b++) if ($urandom_range(1, 0) == 1) m[b*8 +: 8] = 8'hFF;
            drive($urandom_range(3, 0) != 0, pool[$urandom_range(7, 0)], $urandom, m,
                  $urandom_range(2, 0) != 0, pool[$urandom_range(7, 0)]);
            checks++; if (bus.RDY0 !== exp_rdy || bus.QV1 !== exp_qv || bus.Q1 !== exp_q) begin
                errors++; $display("FAIL rand%0d: got rdy=%b qv=%b q=%h exp rdy=%b qv=%b q=%h",
                                   n, bus.RDY0, bus.QV1, bus.Q1, exp_rdy, exp_qv, exp_q); end
        end
        checks++; if (bus.STAT_CONFLICTS !== (STATS_ON ? exp_conf : 32'd0) ||
                      bus.STAT_STALLS !== (STATS_ON ? exp_stall : 32'd0)) begin
            errors++; $display("FAIL rand_stats: got %0d/%0d exp %0d/%0d", bus.STAT_CONFLICTS, bus.STAT_STALLS,
                               STATS_ON ? exp_conf : 32'd0, STATS_ON ? exp_stall : 32'd0); end
    endtask

    task automatic test_reset_mid();
        logic [DW-1:0] old_a, old_b;
        idle(); idle(); idle();
        old_a = visible(14'h0020);
        old_b = visible(14'h0021);
        drive(1'b1, 14'h0020, ~old_a, '1, 1'b1, 14'h0010);
        drive(1'b1, 14'h0021, ~old_b, '1, 1'b1, 14'h0005);
        checks++; if (int'(dut.u_wbuf.r_count) != 2 || bus.RDY0 !== 1'b0) begin
            errors++; $display("FAIL rm_full: got count=%0d rdy=%b exp 2/0", dut.u_wbuf.r_count, bus.RDY0); end
        #2 rstn = 1'b0;
        #1;
        mdl_reset();
        checks++; if (bus.RDY0 !== 1'b1 || bus.QV1 !== 1'b0) begin
            errors++; $display("FAIL rm_ctrl: got rdy=%b qv=%b exp 1/0", bus.RDY0, bus.QV1); end
        checks++; if (bus.STAT_CONFLICTS !== 32'd0 || bus.STAT_STALLS !== 32'd0) begin
            errors++; $display("FAIL rm_stats: got %0d/%0d exp 0/0", bus.STAT_CONFLICTS, bus.STAT_STALLS); end
        bus.CE0 = 1'b0; bus.CE1 = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rstn = 1'b1;
        drive(1'b0, '0, '0, '0, 1'b1, 14'h0020);
        checks++; if (bus.Q1 !== old_a || bus.Q1 !== exp_q) begin
            errors++; $display("FAIL rm_keep_a: got %h exp %h", bus.Q1, old_a); end
        drive(1'b0, '0, '0, '0, 1'b1, 14'h0021);
        checks++; if (bus.Q1 !== old_b || bus.Q1 !== exp_q) begin
            errors++; $display("FAIL rm_keep_b: got %h exp %h", bus.Q1, old_b); end
    endtask

    initial begin
        pool = '{14'h0005, 14'h0010, 14'h0020, 14'h0021, 14'h0100, 14'h2001, 14'h2003, 14'h2010};
        test_reset();
        test_basic();
        test_conflict_forward();
        test_read_before_write();
        test_fill();
        test_partial_mask();
        test_random();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/gf22_sram_be_wbuf_banked.md
Name: gf22_sram_be_wbuf_banked

Overview:
Parametrised 1-write/1-read byte-masked SRAM built from 2^(ADDR_W-BANK_ADDR_W) single-port banks, the successor to the fixed 1w:1r banked wrappers.
- A write that collides with a same-cycle read on the same bank is not dropped. It is parked in a small in-order write buffer and drained when its bank is idle.
- Reads forward pending buffered bytes, so read-after-write is coherent.
- Sits between accelerator PLM ports and GF22 single-port macros.

Parameters:
DATA_W, 32, word width in bits; multiple of 8.
ADDR_W, 14, word address width.
BANK_ADDR_W, 13, per-bank address width; NBANKS = 2^(ADDR_W-BANK_ADDR_W), with ADDR_W > BANK_ADDR_W.
WBUF_DEPTH, 2, write-buffer entries (1..8).

Ports:
CLK  in  1  clock.
RSTN  in  1  reset, asynchronous, active-low.
CE0  in  1  write request valid.
A0  in  ADDR_W  write word address.
D0  in  DATA_W  write data.
WEM0  in  DATA_W  per-bit write mask, byte-granular in practice.
RDY0  out  1  write accepted this cycle when CE0 & RDY0.
CE1  in  1  read request; always accepted.
A1  in  ADDR_W  read address.
Q1  out  DATA_W  read data.
QV1  out  1  Q1 valid.
STAT_CONFLICTS  out  32  bank-conflict count (optional feature).
STAT_STALLS  out  32  cycles with CE0 & !RDY0 (optional feature).

Behaviour:
- Bank select is addr[ADDR_W-1:BANK_ADDR_W]; bank address is addr[BANK_ADDR_W-1:0].
- Reset values: buffer empty, RDY0=1, QV1=0, Q1=0, stats=0.
- Reset mid-operation discards buffered writes; no bank is written during reset.
- RDY0 = (count < WBUF_DEPTH), taken from the registered count. There is no same-cycle full pass-through.
- Per-cycle bank arbitration, in priority order:
  1) Read: when CE1, bank rb performs the read.
  2) Drain: when the buffer is non-empty and head bank != rb (or !CE1), the head is written to its bank and popped.
  3) Direct write: an accepted write goes straight to its bank only if the buffer is empty and no drain occurs, and wb != rb. Otherwise it is pushed to the tail.
  - A write is never reordered with respect to older buffered writes.
  - Accepted writes with WEM0==0 are no-ops and are not buffered.
- Simultaneous pop and push in one cycle are allowed; count is unchanged.
- Read latency is 1. QV1 is asserted in cycle t+1 for CE1 at t, and is 0 otherwise.
  - Q1 holds its last value when QV1=0.
- Forwarding (read-before-write semantics):
  - At cycle t, every buffer entry valid at the start of t with address == A1 contributes its masked bytes, oldest to youngest, younger bytes winning.
  - A write accepted in the same cycle t is NOT visible to that read.
  - The merge mask and data are registered. Q1 = (bankQ & ~mask) | (fwd & mask).
  - The draining entry can never match A1, because drain is to a different bank.
- The buffer is a FIFO with wrap-around pointers; its count saturates at WBUF_DEPTH by construction.

Optional Feature:
Macro GF22_SRAM_BE_STATS_EN.
- When defined: STAT_CONFLICTS increments when CE0&RDY0&CE1 and wb==rb. STAT_STALLS increments on CE0&!RDY0. Both saturate at 2^32-1 and reset to 0.
- When undefined: both ports are tied to 0 and no counter logic is present.

Decomposition:
- Package gf22_sram_pkg holds the NBANKS derivation function, the bank-select helper and the byte-merge function.
- One sub-module, gf22_sram_wbuf, contains the FIFO storage, pointers, count and the CAM-style forward merge for one address.
- Banks are the existing GF22 single-port macros of size 2^BANK_ADDR_W x DATA_W, chosen by generate.

Test Plan:
1. Write A0=0x0005, D0=0xAABBCCDD, WEM0=all-ones, no read; then read 0x0005 → QV1=1 one cycle after CE1, Q1=0xAABBCCDD.
2. Same-cycle write 0x2001 and read 0x2003 (both bank 1) → write buffered (count=1), RDY0 stays 1. An immediately following read of 0x2001 → Q1 equals forwarded data. The write drains on the next cycle with no bank-1 read, and the bank then holds the data.
3. Read-before-write: write 0x0010=0x11111111 and read 0x0010 in the same cycle → Q1 is the old value. The next read → 0x11111111.
4. Buffer fill: hold a bank-0 read every cycle with three writes to bank 0 → RDY0 drops after 2 accepts; the third write is held until a read-free cycle drains the head. Final contents are in order, with later writes to the same address overwriting earlier ones.
5. Partial mask merge: buffered write WEM0=0x0000FFFF, D0=0x0000BEEF over a bank word of 0x12345678, then read → Q1=0x1234BEEF.
6. Assert RSTN=0 with 2 buffered writes → RDY0=1 and QV1=0 immediately; the banks keep their pre-reset contents; stats are 0 (with GF22_SRAM_BE_STATS_EN).
